// File: rtl/jtframe_prog_arb_if.sv
// Bus bundle between the download/aux requesters, the programming arbiter and the SDRAM prog port.
// The arbiter uses the master view; the surrounding logic uses the slave view.
interface jtframe_prog_arb_if;
  logic        downloading;

  logic        a_req;
  logic [21:0] a_addr;
  logic [15:0] a_data;
  logic [1:0]  a_mask;
  logic [1:0]  a_ba;
  logic        a_ack;

  logic        b_req;
  logic [21:0] b_addr;
  logic [15:0] b_data;
  logic [1:0]  b_mask;
  logic [1:0]  b_ba;
  logic        b_ack;

  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_ba;
  logic        prog_we;
  logic        prog_rd;
  logic        sdram_ack;

  logic        busy;
  logic        timeout_err;

  modport master (
    input  downloading,
    input  a_req, a_addr, a_data, a_mask, a_ba,
    output a_ack,
    input  b_req, b_addr, b_data, b_mask, b_ba,
    output b_ack,
    output prog_addr, prog_data, prog_mask, prog_ba, prog_we, prog_rd,
    input  sdram_ack,
    output busy, timeout_err
  );

  modport slave (
    output downloading,
    output a_req, a_addr, a_data, a_mask, a_ba,
    input  a_ack,
    output b_req, b_addr, b_data, b_mask, b_ba,
    input  b_ack,
    input  prog_addr, prog_data, prog_mask, prog_ba, prog_we, prog_rd,
    output sdram_ack,
    input  busy, timeout_err
  );
endinterface

// File: rtl/jtframe_prog_arb.sv
// Shares the SDRAM programming port between the ROM download stream (A) and an aux loader (B).
// One write in flight at a time, held until sdram_ack, guarded by a watchdog.
module jtframe_prog_arb #(
  parameter logic [15:0] TIMEOUT = 16'd1023
) (
  input logic                clk,
  input logic                rst,
  jtframe_prog_arb_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state;
  logic        last;
  logic        owner;
  logic        dl_p1;
  logic [15:0] cnt;

  logic        grant;
  logic        sel_b;
  logic        abort;
  logic        expired;

  // Returns {grant, select_b}. During a download only A may be served.
  function automatic logic [1:0] arbitrate(input logic dl, input logic a,
                                           input logic b, input logic lst);
    logic [1:0] res;
    res = 2'b00;
    if (dl) begin
      res = {a, 1'b0};
    end else if (a && b) begin
      res = {1'b1, ~lst};
    end else if (a) begin
      res = 2'b10;
    end else if (b) begin
      res = 2'b11;
    end
    return res;
  endfunction

  always_comb begin
    {grant, sel_b} = arbitrate(bus.downloading, bus.a_req, bus.b_req, last);
    abort   = (state == WAIT) && !owner && dl_p1 && !bus.downloading;
    expired = (TIMEOUT != 16'd0) && (cnt == TIMEOUT - 16'd1);
  end

  assign bus.prog_rd = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      last            <= 1'b1;
      owner           <= 1'b0;
      dl_p1           <= 1'b0;
      cnt             <= 16'd0;
      bus.prog_addr   <= 22'd0;
      bus.prog_data   <= 16'd0;
      bus.prog_mask   <= 2'b11;
      bus.prog_ba     <= 2'd0;
      bus.prog_we     <= 1'b0;
      bus.a_ack       <= 1'b0;
      bus.b_ack       <= 1'b0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      dl_p1 <= bus.downloading;
      case (state)
        IDLE: begin
          bus.a_ack <= 1'b0;
          bus.b_ack <= 1'b0;
          if (grant) begin
            if (sel_b) begin
              bus.prog_addr <= bus.b_addr;
              bus.prog_data <= bus.b_data;
              bus.prog_mask <= bus.b_mask;
              bus.prog_ba   <= bus.b_ba;
            end else begin
              bus.prog_addr <= bus.a_addr;
              bus.prog_data <= bus.a_data;
              bus.prog_mask <= bus.a_mask;
              bus.prog_ba   <= bus.a_ba;
            end
            bus.prog_we <= 1'b1;
            cnt         <= 16'd0;
            owner       <= sel_b;
            last        <= sel_b;
            bus.busy    <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // A real ack beats both abort and watchdog: the write did land.
          if (bus.sdram_ack) begin
            bus.prog_we <= 1'b0;
            bus.a_ack   <= ~owner;
            bus.b_ack   <= owner;
            state       <= GAP;
          end else if (abort) begin
            bus.prog_we <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end else if (expired) begin
            bus.prog_we     <= 1'b0;
            bus.a_ack       <= ~owner;
            bus.b_ack       <= owner;
            bus.timeout_err <= 1'b1;
            state           <= GAP;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          bus.a_ack <= 1'b0;
          bus.b_ack <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          bus.prog_we <= 1'b0;
          bus.a_ack   <= 1'b0;
          bus.b_ack   <= 1'b0;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_prog_arb.sv
// Bench for jtframe_prog_arb: vector table, directed priority/watchdog sequences, random traffic vs a rule model.
module tb_jtframe_prog_arb;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  jtframe_prog_arb_if bus();

  jtframe_prog_arb #(.TIMEOUT(16'd8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [41:0] AF = {22'h00123, 16'hA55A, 2'b10, 2'b01};
  localparam logic [41:0] BF = {22'h3ABCD, 16'h5AA5, 2'b01, 2'b10};
  localparam logic [41:0] RF = {22'd0, 16'd0, 2'b11, 2'd0};

  typedef struct {
    logic        rst, dl, ar, br, sack;
    logic        we, aa, ba, busy, terr;
    logic [41:0] fld;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t v(input logic [4:0] in, input logic [4:0] ex, input logic [41:0] f);
    vec_t r;
    {r.rst, r.dl, r.ar, r.br, r.sack} = in;
    {r.we, r.aa, r.ba, r.busy, r.terr} = ex;
    r.fld = f;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [41:0] prog_fld;
    return {bus.prog_addr, bus.prog_data, bus.prog_mask, bus.prog_ba};
  endfunction

  // random-phase model and agent state
  logic [41:0] exp_fld, sa_f, sb_f;
  logic        m_last, m_owner, we_prev, sa_req, sb_req, s_ack;
  logic        e_we, e_aa, e_ba, e_busy, granted;
  int          free_at, ack_wait, a_wait, b_wait;
  int          aacks, bearly, bdone, nhigh, served_a, served_b;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.downloading = 1'b0;
    bus.a_req = 1'b0; bus.b_req = 1'b0; bus.sdram_ack = 1'b0;
    {bus.a_addr, bus.a_data, bus.a_mask, bus.a_ba} = AF;
    {bus.b_addr, bus.b_data, bus.b_mask, bus.b_ba} = BF;

    // in = {rst,dl,a_req,b_req,sdram_ack}, ex = {we,a_ack,b_ack,busy,timeout_err}
    tbl[0]  = v(5'b10000, 5'b00000, RF);  // reset state
    tbl[1]  = v(5'b01100, 5'b10010, AF);  // single A write, grant
    tbl[2]  = v(5'b01100, 5'b10010, AF);
    tbl[3]  = v(5'b01101, 5'b01010, AF);  // ack after 2 we cycles
    tbl[4]  = v(5'b01000, 5'b00000, AF);
    tbl[5]  = v(5'b01000, 5'b00000, AF);
    tbl[6]  = v(5'b00001, 5'b00000, AF);  // stray ack in IDLE
    tbl[7]  = v(5'b10000, 5'b00000, RF);  // reset: last=B so A wins the tie
    tbl[8]  = v(5'b00110, 5'b10010, AF);  // round robin A,B,A,B
    tbl[9]  = v(5'b00111, 5'b01010, AF);
    tbl[10] = v(5'b00110, 5'b00000, AF);
    tbl[11] = v(5'b00110, 5'b10010, BF);
    tbl[12] = v(5'b00111, 5'b00110, BF);
    tbl[13] = v(5'b00110, 5'b00000, BF);
    tbl[14] = v(5'b00110, 5'b10010, AF);
    tbl[15] = v(5'b00111, 5'b01010, AF);
    tbl[16] = v(5'b00110, 5'b00000, AF);
    tbl[17] = v(5'b00110, 5'b10010, BF);
    tbl[18] = v(5'b00111, 5'b00110, BF);
    tbl[19] = v(5'b00110, 5'b00000, BF);
    tbl[20] = v(5'b01110, 5'b10010, AF);  // A granted under download
    tbl[21] = v(5'b00110, 5'b00000, AF);  // download drops: abort, no ack
    tbl[22] = v(5'b00010, 5'b10010, BF);  // pending B after one IDLE cycle
    tbl[23] = v(5'b00010, 5'b10010, BF);
    tbl[24] = v(5'b10010, 5'b00000, RF);  // reset mid-WAIT
    tbl[25] = v(5'b00001, 5'b00000, RF);  // late ack ignored
    tbl[26] = v(5'b00000, 5'b00000, RF);

    for (int i = 0; i < 27; i++) begin
      rst = tbl[i].rst;
      bus.downloading = tbl[i].dl;
      bus.a_req = tbl[i].ar;
      bus.b_req = tbl[i].br;
      bus.sdram_ack = tbl[i].sack;
      tick();
      check($sformatf("v%0d_we", i),   64'(bus.prog_we),     64'(tbl[i].we));
      check($sformatf("v%0d_aack", i), 64'(bus.a_ack),       64'(tbl[i].aa));
      check($sformatf("v%0d_back", i), 64'(bus.b_ack),       64'(tbl[i].ba));
      check($sformatf("v%0d_busy", i), 64'(bus.busy),        64'(tbl[i].busy));
      check($sformatf("v%0d_terr", i), 64'(bus.timeout_err), 64'(tbl[i].terr));
      check($sformatf("v%0d_fld", i),  64'(prog_fld()),      64'(tbl[i].fld));
      check($sformatf("v%0d_rd", i),   64'(bus.prog_rd),     64'(0));
    end

    // Priority: A monopolises the port while downloading, B served afterwards.
    rst = 1'b0;
    bus.downloading = 1'b1; bus.a_req = 1'b1; bus.b_req = 1'b1; bus.sdram_ack = 1'b0;
    aacks = 0; bearly = 0; bdone = 0;
    for (int i = 0; i < 60 && bdone == 0; i++) begin
      tick();
      if (bus.a_ack) begin
        aacks++;
        check("prio_a_fld", 64'(prog_fld()), 64'(AF));
      end
      if (bus.b_ack) begin
        if (bus.downloading) bearly++;
        else begin
          bdone = 1;
          check("prio_b_fld", 64'(prog_fld()), 64'(BF));
        end
      end
      bus.sdram_ack = bus.prog_we;
      if (aacks == 4 && bus.downloading) begin
        bus.a_req = 1'b0;
        bus.downloading = 1'b0;
      end
    end
    check("prio_a_count", 64'(aacks), 64'(4));
    check("prio_b_early", 64'(bearly), 64'(0));
    check("prio_b_served", 64'(bdone), 64'(1));
    bus.b_req = 1'b0; bus.sdram_ack = 1'b0;
    tick(); tick();

    // Watchdog with TIMEOUT=8 and no sdram_ack.
    bus.a_req = 1'b1;
    nhigh = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.prog_we) nhigh++;
      else if (nhigh > 0) break;
    end
    check("wd_we_cycles", 64'(nhigh), 64'(8));
    check("wd_aack", 64'(bus.a_ack), 64'(1));
    check("wd_terr", 64'(bus.timeout_err), 64'(1));
    bus.a_req = 1'b0;
    tick(); tick(); tick();
    check("wd_terr_sticky", 64'(bus.timeout_err), 64'(1));
    check("wd_idle", 64'(bus.busy), 64'(0));
    rst = 1'b1;
    tick();
    check("wd_terr_rst", 64'(bus.timeout_err), 64'(0));
    tick();
    rst = 1'b0;

    // Random traffic, downloading=0, acks within 0..4 cycles plus stray acks.
    m_last = 1'b1; m_owner = 1'b0; we_prev = 1'b0; exp_fld = RF;
    free_at = 0; ack_wait = 0; a_wait = 0; b_wait = 0; served_a = 0; served_b = 0;
    for (int e = 0; e < 2000; e++) begin
      sa_req = bus.a_req; sb_req = bus.b_req; s_ack = bus.sdram_ack;
      sa_f = {bus.a_addr, bus.a_data, bus.a_mask, bus.a_ba};
      sb_f = {bus.b_addr, bus.b_data, bus.b_mask, bus.b_ba};
      tick();
      e_aa = 1'b0; e_ba = 1'b0; granted = 1'b0;
      if (we_prev) begin
        e_busy = 1'b1;
        if (s_ack) begin
          e_we = 1'b0;
          if (m_owner) e_ba = 1'b1; else e_aa = 1'b1;
          free_at = e + 2;
        end else begin
          e_we = 1'b1;
        end
      end else if (e >= free_at && (sa_req || sb_req)) begin
        m_owner = (sa_req && sb_req) ? ~m_last : sb_req;
        m_last = m_owner;
        exp_fld = m_owner ? sb_f : sa_f;
        e_we = 1'b1; e_busy = 1'b1; granted = 1'b1;
      end else begin
        e_we = 1'b0; e_busy = 1'b0;
      end
      check("rnd_we",   64'(bus.prog_we), 64'(e_we));
      check("rnd_aack", 64'(bus.a_ack),   64'(e_aa));
      check("rnd_back", 64'(bus.b_ack),   64'(e_ba));
      check("rnd_busy", 64'(bus.busy),    64'(e_busy));
      check("rnd_fld",  64'(prog_fld()),  64'(exp_fld));
      check("rnd_terr", 64'(bus.timeout_err), 64'(0));
      we_prev = e_we;
      if (e_aa) served_a++;
      if (e_ba) served_b++;

      if (granted) ack_wait = $urandom_range(0, 4);
      if (e_we) begin
        bus.sdram_ack = (ack_wait == 0);
        if (ack_wait > 0) ack_wait--;
      end else begin
        bus.sdram_ack = ($urandom_range(0, 9) == 0);
      end

      if (bus.a_req) begin
        if (e_aa) begin
          if ($urandom_range(0, 1) == 1) begin
            bus.a_addr = 22'($urandom); bus.a_data = 16'($urandom);
            bus.a_mask = 2'($urandom);  bus.a_ba = 2'($urandom);
          end else begin
            bus.a_req = 1'b0;
            a_wait = $urandom_range(0, 3);
          end
        end
      end else if (a_wait > 0) begin
        a_wait--;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.a_addr = 22'($urandom); bus.a_data = 16'($urandom);
        bus.a_mask = 2'($urandom);  bus.a_ba = 2'($urandom);
        bus.a_req = 1'b1;
      end

      if (bus.b_req) begin
        if (e_ba) begin
          if ($urandom_range(0, 1) == 1) begin
            bus.b_addr = 22'($urandom); bus.b_data = 16'($urandom);
            bus.b_mask = 2'($urandom);  bus.b_ba = 2'($urandom);
          end else begin
            bus.b_req = 1'b0;
            b_wait = $urandom_range(0, 3);
          end
        end
      end else if (b_wait > 0) begin
        b_wait--;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.b_addr = 22'($urandom); bus.b_data = 16'($urandom);
        bus.b_mask = 2'($urandom);  bus.b_ba = 2'($urandom);
        bus.b_req = 1'b1;
      end
    end
    check("rnd_a_active", 64'(served_a > 0), 64'(1));
    check("rnd_b_active", 64'(served_b > 0), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
